conv_mem_arbiter: RTL and testbench

- Round-robin arbiter that shares the single CONV scratch-memory port among the layer engines: L0 conv writer, L1 max-pool reader/writer and L2 flatten reader/writer.
- The shared port is cwr/crd/csel/caddr_wr/caddr_rd/cdata_wr/cdata_rd.
- Sits between the engines and the top-level CONV memory pins.
- Issues at most one memory command per cycle and returns read data to the requester that issued it.

---
 rtl/conv_mem_arbiter_if.sv | 45 ++++
 rtl/conv_mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_conv_mem_arbiter.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_mem_arbiter_if.sv
// conv_mem_arbiter_if
//   Requester-side bundle for conv_mem_arbiter. The layer engines drive the
//   command fields; the arbiter returns grant and read-response signals.
//   Field i of every packed vector belongs to requester i (0 = L0, 1 = L1, 2 = L2).
//
//   req        engines -> arbiter  per-requester command valid
//   req_we     engines -> arbiter  1 = write, 0 = read
//   req_sel    engines -> arbiter  3-bit csel per requester, slice [3i+2:3i]
//   req_addr   engines -> arbiter  AW-bit address per requester
//   req_wdata  engines -> arbiter  DW-bit write data per requester
//   req_lock   engines -> arbiter  lock request (only with ARB_LOCK_EN defined)
//   gnt        arbiter -> engines  one-hot combinational command accept
//   rsp_valid  arbiter -> engines  one-hot read-data valid
//   rsp_data   arbiter -> engines  read data
//
//   Optional feature macro: ARB_LOCK_EN (adds req_lock).
interface conv_mem_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 12,
    parameter int DW   = 20
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_we;
    logic [3*NREQ-1:0]  req_sel;
    logic [AW*NREQ-1:0] req_addr;
    logic [DW*NREQ-1:0] req_wdata;
`ifdef ARB_LOCK_EN
    logic [NREQ-1:0]    req_lock;
`endif
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;

`ifdef ARB_LOCK_EN
    modport master (output req, req_we, req_sel, req_addr, req_wdata, req_lock,
                    input  gnt, rsp_valid, rsp_data);
    modport slave  (input  req, req_we, req_sel, req_addr, req_wdata, req_lock,
                    output gnt, rsp_valid, rsp_data);
`else
    modport master (output req, req_we, req_sel, req_addr, req_wdata,
                    input  gnt, rsp_valid, rsp_data);
    modport slave  (input  req, req_we, req_sel, req_addr, req_wdata,
                    output gnt, rsp_valid, rsp_data);
`endif
endinterface

// File: rtl/conv_mem_arbiter.sv
// conv_mem_arbiter
//   Round-robin arbiter sharing the single CONV scratch-memory port among
//   the layer engines (L0 conv writer, L1 max-pool, L2 flatten).
//   Stage A grants combinationally, stage B drives registered memory
//   strobes, stage C registers read data and steers it back to its owner.
//
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   bus        slave modport of conv_mem_arbiter_if (requests, gnt, responses)
//   sel_err    out  sticky: a command with csel 0, 6 or 7 was granted
//   cwr/crd    out  memory write / read strobes (never both high)
//   csel       out  memory bank select
//   caddr_wr   out  write address
//   caddr_rd   out  read address
//   cdata_wr   out  write data
//   cdata_rd   in   read data, valid at the edge ending the crd cycle
//
//   Optional feature macro: ARB_LOCK_EN (bus lock with 16-cycle idle timeout).
module conv_mem_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 12,
    parameter int DW   = 20
) (
    input  logic              clk,
    input  logic              reset,
    conv_mem_arbiter_if.slave bus,
    output logic              sel_err,
    output logic              cwr,
    output logic              crd,
    output logic [2:0]        csel,
    output logic [AW-1:0]     caddr_wr,
    output logic [AW-1:0]     caddr_rd,
    output logic [DW-1:0]     cdata_wr,
    input  logic [DW-1:0]     cdata_rd
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0]   ptr;
    logic [IW-1:0]   ptr_next_rr;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] gnt_vec;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_any;
    logic            ptr_advance;
    logic            g_we;
    logic            g_legal;
    logic [2:0]      g_sel;
    logic [AW-1:0]   g_addr;
    logic [DW-1:0]   g_wdata;
    logic [NREQ-1:0] b_rd_oh;
    logic [NREQ-1:0] rsp_valid_q;
    logic [DW-1:0]   rsp_data_q;

`ifdef ARB_LOCK_EN
    typedef enum logic {ARB_RR, ARB_LOCKED} arb_state_t;
    arb_state_t      state;
    arb_state_t      state_next;
    logic [NREQ-1:0] lock_owner;
    logic [3:0]      lock_cnt;
    logic            g_lock;
    logic            owner_req;

    // While locked only the owner is eligible; grants are masked during reset.
    assign eligible  = reset ? '0 : ((state == ARB_LOCKED) ? (bus.req & lock_owner) : bus.req);
    assign owner_req = |(bus.req & lock_owner);

    always_comb begin
        g_lock = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_vec[i]) g_lock = bus.req_lock[i];
        end
    end

    // Lock exits on an unlocked owner grant or after 16 idle owner cycles.
    always_comb begin
        state_next = state;
        case (state)
            ARB_RR: begin
                if (gnt_any && g_lock) state_next = ARB_LOCKED;
            end
            ARB_LOCKED: begin
                if (owner_req) begin
                    if (!g_lock) state_next = ARB_RR;
                end else if (lock_cnt == 4'd15) begin
                    state_next = ARB_RR;
                end
            end
            default: state_next = ARB_RR;
        endcase
    end

    // The pointer is frozen on grants that enter or stay in LOCKED.
    assign ptr_advance = gnt_any && (state_next == ARB_RR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_RR;
            lock_owner <= '0;
            lock_cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == ARB_RR && state_next == ARB_LOCKED) lock_owner <= gnt_vec;
            if (state == ARB_LOCKED && !owner_req) lock_cnt <= lock_cnt + 4'd1;
            else                                   lock_cnt <= '0;
        end
    end
`else
    assign eligible    = reset ? '0 : bus.req;
    assign ptr_advance = gnt_any;
`endif

    // Two passes give the wrap-around scan: indices >= ptr first, then < ptr.
    always_comb begin
        gnt_vec = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_any && eligible[i] && (i >= int'(ptr))) begin
                gnt_vec[i] = 1'b1;
                gnt_idx    = i[IW-1:0];
                gnt_any    = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_any && eligible[i] && (i < int'(ptr))) begin
                gnt_vec[i] = 1'b1;
                gnt_idx    = i[IW-1:0];
                gnt_any    = 1'b1;
            end
        end
    end

    always_comb begin
        g_we    = 1'b0;
        g_sel   = '0;
        g_addr  = '0;
        g_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_vec[i]) begin
                g_we    = bus.req_we[i];
                g_sel   = bus.req_sel[3*i +: 3];
                g_addr  = bus.req_addr[AW*i +: AW];
                g_wdata = bus.req_wdata[DW*i +: DW];
            end
        end
    end

    assign g_legal     = (g_sel >= 3'd1) && (g_sel <= 3'd5);
    assign ptr_next_rr = (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + IW'(1);

    assign bus.gnt       = gnt_vec;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

    // Illegal-csel grants retire silently: no strobe, no response, only sel_err.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr         <= '0;
            cwr         <= 1'b0;
            crd         <= 1'b0;
            csel        <= '0;
            caddr_wr    <= '0;
            caddr_rd    <= '0;
            cdata_wr    <= '0;
            b_rd_oh     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            sel_err     <= 1'b0;
        end else begin
            if (ptr_advance) ptr <= ptr_next_rr;
            cwr     <= gnt_any && g_we && g_legal;
            crd     <= gnt_any && !g_we && g_legal;
            b_rd_oh <= (gnt_any && !g_we && g_legal) ? gnt_vec : '0;
            if (gnt_any && g_legal) begin
                csel <= g_sel;
                if (g_we) begin
                    caddr_wr <= g_addr;
                    cdata_wr <= g_wdata;
                end else begin
                    caddr_rd <= g_addr;
                end
            end
            if (gnt_any && !g_legal) sel_err <= 1'b1;
            rsp_valid_q <= b_rd_oh;
            if (|b_rd_oh) rsp_data_q <= cdata_rd;
        end
    end
endmodule

// File: tb/tb_conv_mem_arbiter.sv
// tb_conv_mem_arbiter
//   Directed bench for conv_mem_arbiter. A tiny address-decoded memory model
//   drives cdata_rd while crd is high. Inputs change 1 ns after each rising
//   edge; outputs are sampled at the same point.
module tb_conv_mem_arbiter;
    localparam int NREQ = 3;
    localparam int AW   = 12;
    localparam int DW   = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          sel_err;
    logic          cwr;
    logic          crd;
    logic [2:0]    csel;
    logic [AW-1:0] caddr_wr;
    logic [AW-1:0] caddr_rd;
    logic [DW-1:0] cdata_wr;
    logic [DW-1:0] cdata_rd;

    int n_vec = 0;
    int n_bad = 0;

    conv_mem_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    conv_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .sel_err  (sel_err),
        .cwr      (cwr),
        .crd      (crd),
        .csel     (csel),
        .caddr_wr (caddr_wr),
        .caddr_rd (caddr_rd),
        .cdata_wr (cdata_wr),
        .cdata_rd (cdata_rd)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
        case (a)
            12'h3FF: return 20'h0ABCD;
            12'h010: return 20'h11111;
            12'h011: return 20'h22222;
            default: return 20'hDEAD0;
        endcase
    endfunction

    assign cdata_rd = crd ? mem_model(caddr_rd) : '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        bus.req       = '0;
        bus.req_we    = '0;
        bus.req_sel   = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
`ifdef ARB_LOCK_EN
        bus.req_lock  = '0;
`endif
    endtask

    task automatic set_cmd(input int i, input logic we, input logic [2:0] sel,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        bus.req[i]                = 1'b1;
        bus.req_we[i]             = we;
        bus.req_sel[3*i +: 3]     = sel;
        bus.req_addr[AW*i +: AW]  = addr;
        bus.req_wdata[DW*i +: DW] = wdata;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_req();
        reset = 1'b1;
        bus.req     = '1;
        bus.req_we  = '1;
        bus.req_sel = {3'd1, 3'd1, 3'd1};
        tick();
        tick();
        n_vec++;
        if (bus.gnt !== 3'b000) begin
            n_bad++;
            $display("[TB] FAIL reset_gnt: got %b expected %b", bus.gnt, 3'b000);
        end
        n_vec++;
        if ({cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr} !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset_mem: got %h expected 0", {cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr});
        end
        n_vec++;
        if ({bus.rsp_valid, bus.rsp_data, sel_err} !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset_rsp: got %h expected 0", {bus.rsp_valid, bus.rsp_data, sel_err});
        end
        clear_req();
        reset = 1'b0;
    endtask

    task automatic test_single_write();
        set_cmd(0, 1'b1, 3'd1, 12'h005, 20'h12345);
        #1;
        n_vec++;
        if (bus.gnt !== 3'b001) begin
            n_bad++;
            $display("[TB] FAIL wr_gnt: got %b expected %b", bus.gnt, 3'b001);
        end
        tick();
        clear_req();
        n_vec++;
        if ({cwr, crd, csel, caddr_wr, cdata_wr} !== {1'b1, 1'b0, 3'd1, 12'h005, 20'h12345}) begin
            n_bad++;
            $display("[TB] FAIL wr_issue: got %h expected %h", {cwr, crd, csel, caddr_wr, cdata_wr},
                     {1'b1, 1'b0, 3'd1, 12'h005, 20'h12345});
        end
        tick();
        n_vec++;
        if ({cwr, crd, csel, bus.rsp_valid} !== {1'b0, 1'b0, 3'd1, 3'b000}) begin
            n_bad++;
            $display("[TB] FAIL wr_idle: got %b expected %b", {cwr, crd, csel, bus.rsp_valid}, 8'b00001000);
        end
    endtask

    task automatic test_single_read();
        set_cmd(1, 1'b0, 3'd3, 12'h3FF, 20'h0);
        #1;
        n_vec++;
        if (bus.gnt !== 3'b010) begin
            n_bad++;
            $display("[TB] FAIL rd_gnt: got %b expected %b", bus.gnt, 3'b010);
        end
        tick();
        clear_req();
        n_vec++;
        if ({cwr, crd, csel, caddr_rd, bus.rsp_valid} !== {1'b0, 1'b1, 3'd3, 12'h3FF, 3'b000}) begin
            n_bad++;
            $display("[TB] FAIL rd_issue: got %h expected %h", {cwr, crd, csel, caddr_rd, bus.rsp_valid},
                     {1'b0, 1'b1, 3'd3, 12'h3FF, 3'b000});
        end
        tick();
        n_vec++;
        if ({bus.rsp_valid, bus.rsp_data, crd} !== {3'b010, 20'h0ABCD, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL rd_rsp: got %h expected %h", {bus.rsp_valid, bus.rsp_data, crd},
                     {3'b010, 20'h0ABCD, 1'b0});
        end
        tick();
        n_vec++;
        if (bus.rsp_valid !== 3'b000) begin
            n_bad++;
            $display("[TB] FAIL rd_rsp_end: got %b expected %b", bus.rsp_valid, 3'b000);
        end
    endtask

    task automatic test_fairness();
        int cnt[NREQ];
        logic [2:0] exp_gnt;
        pulse_reset();
        for (int i = 0; i < NREQ; i++) begin
            cnt[i] = 0;
            set_cmd(i, 1'b1, 3'd1, AW'(i), DW'(i));
        end
        for (int c = 0; c < 9; c++) begin
            #1;
            exp_gnt = 3'b001 << (c % 3);
            n_vec++;
            if (bus.gnt !== exp_gnt) begin
                n_bad++;
                $display("[TB] FAIL fair_gnt[%0d]: got %b expected %b", c, bus.gnt, exp_gnt);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (bus.gnt[i]) cnt[i]++;
            end
            tick();
        end
        clear_req();
        for (int i = 0; i < NREQ; i++) begin
            n_vec++;
            if (cnt[i] !== 3) begin
                n_bad++;
                $display("[TB] FAIL fair_count[%0d]: got %0d expected 3", i, cnt[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_req();
        set_cmd(1, 1'b0, 3'd2, 12'h010, 20'h0);
        #1;
        n_vec++;
        if (bus.gnt !== 3'b010) begin
            n_bad++;
            $display("[TB] FAIL b2b_gnt0: got %b expected %b", bus.gnt, 3'b010);
        end
        tick();
        clear_req();
        set_cmd(2, 1'b1, 3'd5, 12'h7FF, 20'h55555);
        #1;
        n_vec++;
        if (bus.gnt !== 3'b100) begin
            n_bad++;
            $display("[TB] FAIL b2b_gnt1: got %b expected %b", bus.gnt, 3'b100);
        end
        n_vec++;
        if ({cwr, crd, csel, caddr_rd} !== {1'b0, 1'b1, 3'd2, 12'h010}) begin
            n_bad++;
            $display("[TB] FAIL b2b_issue0: got %h expected %h", {cwr, crd, csel, caddr_rd}, {1'b0, 1'b1, 3'd2, 12'h010});
        end
        tick();
        clear_req();
        set_cmd(1, 1'b0, 3'd2, 12'h011, 20'h0);
        #1;
        n_vec++;
        if (bus.gnt !== 3'b010) begin
            n_bad++;
            $display("[TB] FAIL b2b_gnt2: got %b expected %b", bus.gnt, 3'b010);
        end
        n_vec++;
        if ({cwr, crd, csel, caddr_wr, cdata_wr} !== {1'b1, 1'b0, 3'd5, 12'h7FF, 20'h55555}) begin
            n_bad++;
            $display("[TB] FAIL b2b_issue1: got %h expected %h", {cwr, crd, csel, caddr_wr, cdata_wr},
                     {1'b1, 1'b0, 3'd5, 12'h7FF, 20'h55555});
        end
        n_vec++;
        if ({bus.rsp_valid, bus.rsp_data} !== {3'b010, 20'h11111}) begin
            n_bad++;
            $display("[TB] FAIL b2b_rsp0: got %h expected %h", {bus.rsp_valid, bus.rsp_data}, {3'b010, 20'h11111});
        end
        tick();
        clear_req();
        #1;
        n_vec++;
        if ({cwr, crd, csel, caddr_rd, bus.rsp_valid} !== {1'b0, 1'b1, 3'd2, 12'h011, 3'b000}) begin
            n_bad++;
            $display("[TB] FAIL b2b_issue2: got %h expected %h", {cwr, crd, csel, caddr_rd, bus.rsp_valid},
                     {1'b0, 1'b1, 3'd2, 12'h011, 3'b000});
        end
        tick();
        n_vec++;
        if ({bus.rsp_valid, bus.rsp_data} !== {3'b010, 20'h22222}) begin
            n_bad++;
            $display("[TB] FAIL b2b_rsp1: got %h expected %h", {bus.rsp_valid, bus.rsp_data}, {3'b010, 20'h22222});
        end
        tick();
        n_vec++;
        if (bus.rsp_valid !== 3'b000) begin
            n_bad++;
            $display("[TB] FAIL b2b_rsp_end: got %b expected %b", bus.rsp_valid, 3'b000);
        end
    endtask

    task automatic test_illegal_sel();
        set_cmd(2, 1'b0, 3'd6, 12'h123, 20'h0);
        #1;
        n_vec++;
        if (bus.gnt !== 3'b100) begin
            n_bad++;
            $display("[TB] FAIL ill_gnt: got %b expected %b", bus.gnt, 3'b100);
        end
        tick();
        clear_req();
        n_vec++;
        if ({cwr, crd, sel_err} !== 3'b001) begin
            n_bad++;
            $display("[TB] FAIL ill_issue: got %b expected %b", {cwr, crd, sel_err}, 3'b001);
        end
        tick();
        n_vec++;
        if ({bus.rsp_valid, sel_err} !== 4'b0001) begin
            n_bad++;
            $display("[TB] FAIL ill_rsp: got %b expected %b", {bus.rsp_valid, sel_err}, 4'b0001);
        end
        tick();
        tick();
        n_vec++;
        if (sel_err !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL ill_sticky: got %b expected %b", sel_err, 1'b1);
        end
    endtask

    task automatic test_reset_midflight();
        set_cmd(0, 1'b0, 3'd1, 12'h3FF, 20'h0);
        #1;
        n_vec++;
        if (bus.gnt !== 3'b001) begin
            n_bad++;
            $display("[TB] FAIL rst_mid_gnt: got %b expected %b", bus.gnt, 3'b001);
        end
        tick();
        clear_req();
        n_vec++;
        if (crd !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL rst_mid_crd: got %b expected %b", crd, 1'b1);
        end
        reset = 1'b1;
        tick();
        n_vec++;
        if ({bus.rsp_valid, sel_err, crd, cwr} !== 6'b0) begin
            n_bad++;
            $display("[TB] FAIL rst_mid_clear: got %b expected %b", {bus.rsp_valid, sel_err, crd, cwr}, 6'b0);
        end
        reset = 1'b0;
        tick();
        n_vec++;
        if (bus.rsp_valid !== 3'b000) begin
            n_bad++;
            $display("[TB] FAIL rst_mid_norsp: got %b expected %b", bus.rsp_valid, 3'b000);
        end
        set_cmd(0, 1'b1, 3'd1, 12'h001, 20'h1);
        set_cmd(2, 1'b1, 3'd1, 12'h002, 20'h2);
        #1;
        n_vec++;
        if (bus.gnt !== 3'b001) begin
            n_bad++;
            $display("[TB] FAIL rst_mid_ptr: got %b expected %b", bus.gnt, 3'b001);
        end
        clear_req();
        tick();
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock();
        pulse_reset();
        clear_req();
        set_cmd(2, 1'b1, 3'd1, 12'h020, 20'h1);
        bus.req_lock[2] = 1'b1;
        #1;
        n_vec++;
        if (bus.gnt !== 3'b100) begin
            n_bad++;
            $display("[TB] FAIL lock_gnt_b1: got %b expected %b", bus.gnt, 3'b100);
        end
        tick();
        set_cmd(0, 1'b1, 3'd1, 12'h030, 20'h3);
        set_cmd(1, 1'b1, 3'd1, 12'h031, 20'h4);
        for (int b = 2; b <= 4; b++) begin
            bus.req_lock[2] = (b < 4);
            #1;
            n_vec++;
            if (bus.gnt !== 3'b100) begin
                n_bad++;
                $display("[TB] FAIL lock_gnt_b%0d: got %b expected %b", b, bus.gnt, 3'b100);
            end
            tick();
        end
        bus.req[2]  = 1'b0;
        bus.req_lock = '0;
        #1;
        n_vec++;
        if (bus.gnt !== 3'b001) begin
            n_bad++;
            $display("[TB] FAIL lock_after0: got %b expected %b", bus.gnt, 3'b001);
        end
        tick();
        bus.req[0] = 1'b0;
        #1;
        n_vec++;
        if (bus.gnt !== 3'b010) begin
            n_bad++;
            $display("[TB] FAIL lock_after1: got %b expected %b", bus.gnt, 3'b010);
        end
        tick();
        clear_req();
        set_cmd(0, 1'b1, 3'd1, 12'h040, 20'h5);
        bus.req_lock[0] = 1'b1;
        #1;
        n_vec++;
        if (bus.gnt !== 3'b001) begin
            n_bad++;
            $display("[TB] FAIL lock_to_gnt: got %b expected %b", bus.gnt, 3'b001);
        end
        tick();
        clear_req();
        set_cmd(1, 1'b1, 3'd1, 12'h041, 20'h6);
        for (int c = 0; c < 16; c++) begin
            #1;
            n_vec++;
            if (bus.gnt !== 3'b000) begin
                n_bad++;
                $display("[TB] FAIL lock_hold[%0d]: got %b expected %b", c, bus.gnt, 3'b000);
            end
            tick();
        end
        n_vec++;
        if (bus.gnt !== 3'b010) begin
            n_bad++;
            $display("[TB] FAIL lock_timeout: got %b expected %b", bus.gnt, 3'b010);
        end
        clear_req();
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        test_reset();
        test_single_write();
        test_single_read();
        test_fairness();
        test_back_to_back();
        test_illegal_sel();
        test_reset_midflight();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
